obuft_bus_arbiter: RTL and testbench
====================================

Name: obuft_bus_arbiter

Overview:
- Shares one tri-state output bus (a bank of OBUFT-style buffers, one per bit, driven through their I/T pins) among NREQ requesters.
- Round-robin arbitration, registered drive enable, and a hold limit per grant.
- Enforced turnaround (all buffers high-Z) between owners, so two owners never drive the bus in the same cycle.
- An external global-tristate input overrides the drive enable, in the same way the primitive buffers honour the global tristate.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, bus data width
- TURN_CYC, 2, high-Z dead cycles after each grant ends (>=1)
- MAX_BEATS, 16, maximum DRIVE cycles per grant; 0 = unlimited

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-high reset
- REQ  in  NREQ  per-requester bus request, level
- DATA  in  NREQ*W  flattened requester data; requester i at [i*W +: W]
- GTS_IN  in  1  global tristate; 1 forces bus high-Z and aborts any grant
- GNT  out  NREQ  one-hot grant, registered
- BUS_I  out  W  data to buffer I pins, registered
- BUS_T  out  1  to buffer T pins; 1 = high-Z
- BUSY  out  1  1 in any state other than IDLE

Behaviour:
- Interface (already decided): one clock CLK; RST is asynchronous and active-high.
- Reset values: GNT=0, BUS_I=0, t_reg=1, state=IDLE, rr_ptr=0, beat counter=0, turn counter=0. BUS_T=1, BUSY=0.
- BUS_T = t_reg OR GTS_IN. This is combinational, so GTS_IN tristates the bus in the same cycle it is asserted, without waiting for a clock edge.
- IDLE:
  - If GTS_IN=0 and any REQ bit is set, select the winner: first set bit searching upward from rr_ptr, wrapping modulo NREQ.
  - On the next edge: GNT=onehot(winner), BUS_I=DATA[winner], t_reg=0, beat=1, go to DRIVE.
  - Latency is REQ sampled high -> GNT and BUS_T=0 visible one cycle later.
- DRIVE, on each edge:
  - BUS_I <= DATA[winner]: one-cycle data latency.
  - Leave DRIVE if GTS_IN=1, or REQ[winner]=0, or (MAX_BEATS!=0 and beat==MAX_BEATS). On leaving: GNT<=0, t_reg<=1, rr_ptr<=(winner+1) mod NREQ, turn<=1, go to TURN.
  - Otherwise beat<=beat+1.
  - BUS_I keeps its last value after leaving DRIVE; it is not cleared.
- TURN:
  - t_reg=1 and GNT=0 throughout. turn increments each cycle.
  - When turn==TURN_CYC, go to IDLE. IDLE may grant in the same cycle it is entered.
  - Minimum gap from the last driven cycle to the next driven cycle is therefore TURN_CYC+1 cycles.
- Boundary rules:
  - Simultaneous requests: round-robin from rr_ptr only; no fixed priority beyond that.
  - A winner that keeps REQ high after MAX_BEATS is cut off. It competes again from IDLE with rr_ptr already past it, so other pending requesters win first.
  - A requester dropping REQ for one cycle loses its grant.
  - GTS_IN=1 in IDLE blocks all grants. GTS_IN=1 in TURN does not change sequencing.
  - RST asserted mid-DRIVE: the bus goes high-Z and GNT clears immediately (asynchronous). rr_ptr returns to 0.
  - Invariant: GNT is zero or one-hot, and GNT!=0 iff (state==DRIVE and t_reg==0).
- Counter widths: beat uses $clog2(MAX_BEATS+1) bits; turn uses $clog2(TURN_CYC+1) bits.

Decomposition:
- Shared package: state enum (IDLE, DRIVE, TURN), plus a function next_rr(req, ptr) returning the winner index.
- One sub-module, rr_pick: combinational round-robin winner select (inputs REQ and rr_ptr; outputs winner index and a valid bit).
- The FSM, counters and output registers stay in obuft_bus_arbiter.

Test Plan:
- Reset: hold RST with REQ=4'b1111 -> GNT=0, BUS_T=1, BUSY=0. Release -> GNT=4'b0001 on the first edge.
- Single owner: REQ[2]=1 for 5 cycles, DATA2=0x5A -> GNT=4'b0100 for 5 cycles, BUS_T=0, BUS_I=0x5A. Then BUS_T=1 for exactly 2 cycles and BUSY drops.
- Round-robin: REQ=4'b1011 held, MAX_BEATS=16 -> grant order 0,1,3,0. Each grant lasts 16 cycles, separated by 2 high-Z cycles. GNT is never two-hot.
- GTS override: GTS_IN=1 mid-DRIVE -> BUS_T=1 in the same cycle. GNT=0 next edge, TURN follows. No grant while GTS_IN stays high.
- Async reset mid-grant: RST pulsed between edges while driving -> BUS_T=1 and GNT=0 immediately, without waiting for an edge. rr_ptr=0.
- Drop and re-request: owner 1 drops REQ for one cycle -> grant ends, turnaround runs. Owner 1 is regranted only if no other REQ is pending.

Source files
------------

// File: rtl/obuft_bus_arbiter_pkg.sv
// obuft_bus_arbiter_pkg: shared FSM state type and round-robin search helper.
package obuft_bus_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

    localparam int MAX_NREQ = 8;

    // Lowest offset from ptr wins, so scan offsets downward and keep the last hit.
    function automatic logic [2:0] next_rr(input logic [MAX_NREQ-1:0] req, input logic [2:0] ptr, input int nreq);
        int idx;
        next_rr = ptr;
        for (int k = nreq - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % nreq;
            if (req[idx]) next_rr = 3'(idx);
        end
    endfunction

endpackage

// File: rtl/obuft_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner select starting at ptr.
module rr_pick
    import obuft_bus_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            valid
);

    logic [MAX_NREQ-1:0] req_ext;
    logic [2:0]          pick;

    assign req_ext = MAX_NREQ'(req);
    assign pick    = next_rr(req_ext, 3'(ptr), NREQ);
    assign winner  = PW'(pick);
    assign valid   = |req;

endmodule

// File: rtl/obuft_bus_arbiter.sv
// obuft_bus_arbiter: round-robin owner of a shared tri-state bus with hold limit,
// enforced high-Z turnaround and a global-tristate override.
module obuft_bus_arbiter
    import obuft_bus_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int W         = 8,
    parameter int TURN_CYC  = 2,
    parameter int MAX_BEATS = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ*W-1:0] DATA,
    input  logic              GTS_IN,
    output logic [NREQ-1:0]   GNT,
    output logic [W-1:0]      BUS_I,
    output logic              BUS_T,
    output logic              BUSY
);

    localparam int PW = $clog2(NREQ);
    localparam int BW = (MAX_BEATS == 0) ? 1 : $clog2(MAX_BEATS + 1);
    localparam int TW = $clog2(TURN_CYC + 1);

    state_t          state, state_n;
    logic [PW-1:0]   rr_ptr, rr_ptr_n, win, win_n, pick;
    logic            pick_ok, can_grant, turn_done, leave;
    logic [BW-1:0]   beat, beat_n;
    logic [TW-1:0]   turn, turn_n;
    logic [NREQ-1:0] gnt_n;
    logic [W-1:0]    bus_i_n;
    logic            t_reg, t_n;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req    (REQ),
        .ptr    (rr_ptr),
        .winner (pick),
        .valid  (pick_ok)
    );

    assign turn_done = (state == TURN) && (turn == TW'(TURN_CYC));
    // The last turnaround cycle behaves as IDLE so a new owner can start on its closing edge.
    assign can_grant = ((state == IDLE) || turn_done) && !GTS_IN && pick_ok;
    assign leave     = GTS_IN || !REQ[win] || ((MAX_BEATS != 0) && (beat == BW'(MAX_BEATS)));

    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        win_n    = win;
        beat_n   = beat;
        turn_n   = turn;
        gnt_n    = GNT;
        bus_i_n  = BUS_I;
        t_n      = t_reg;
        if (state == DRIVE) begin
            bus_i_n = DATA[win*W +: W];
            if (leave) begin
                state_n  = TURN;
                gnt_n    = '0;
                t_n      = 1'b1;
                rr_ptr_n = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                turn_n   = TW'(1);
            end else begin
                beat_n = beat + 1'b1;
            end
        end else if (can_grant) begin
            state_n = DRIVE;
            win_n   = pick;
            gnt_n   = NREQ'(1) << pick;
            bus_i_n = DATA[pick*W +: W];
            t_n     = 1'b0;
            beat_n  = BW'(1);
        end else if (state == TURN) begin
            state_n = turn_done ? IDLE : TURN;
            turn_n  = turn_done ? turn : turn + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            rr_ptr <= '0;
            win    <= '0;
            beat   <= '0;
            turn   <= '0;
            GNT    <= '0;
            BUS_I  <= '0;
            t_reg  <= 1'b1;
        end else begin
            state  <= state_n;
            rr_ptr <= rr_ptr_n;
            win    <= win_n;
            beat   <= beat_n;
            turn   <= turn_n;
            GNT    <= gnt_n;
            BUS_I  <= bus_i_n;
            t_reg  <= t_n;
        end
    end

    assign BUS_T = t_reg | GTS_IN;
    assign BUSY  = (state != IDLE);

endmodule

// File: tb/tb_obuft_bus_arbiter.sv
// tb_obuft_bus_arbiter: directed stimulus, ownership-level reference model and literal checks.
module tb_obuft_bus_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int TC   = 2;
    localparam int MB   = 16;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [NREQ-1:0]   REQ = '0;
    logic [NREQ*W-1:0] DATA = {8'hC3, 8'h5A, 8'h3C, 8'h11};
    logic              GTS_IN = 1'b0;
    logic [NREQ-1:0]   GNT;
    logic [W-1:0]      BUS_I;
    logic              BUS_T;
    logic              BUSY;

    int checks = 0;
    int failures = 0;

    obuft_bus_arbiter #(.NREQ(NREQ), .W(W), .TURN_CYC(TC), .MAX_BEATS(MB)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQ    (REQ),
        .DATA   (DATA),
        .GTS_IN (GTS_IN),
        .GNT    (GNT),
        .BUS_I  (BUS_I),
        .BUS_T  (BUS_T),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    // Reference model: who owns the bus, how long it has held it, and how many
    // dead cycles remain before the bus may be handed over again.
    int         m_owner = -1;
    int         m_beats = 0;
    int         m_dead  = 0;
    int         m_ptr   = 0;
    logic [W-1:0] m_bus = '0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_owner = -1;
            m_beats = 0;
            m_dead  = 0;
            m_ptr   = 0;
            m_bus   = '0;
        end else if (m_owner >= 0) begin
            m_bus = DATA[m_owner*W +: W];
            if (GTS_IN || !REQ[m_owner] || m_beats == MB) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_dead  = TC;
            end else begin
                m_beats++;
            end
        end else if (m_dead > 1) begin
            m_dead--;
        end else begin
            m_dead = 0;
            if (!GTS_IN)
                for (int k = 0; k < NREQ; k++)
                    if (m_owner < 0 && REQ[(m_ptr + k) % NREQ]) begin
                        m_owner = (m_ptr + k) % NREQ;
                        m_beats = 1;
                        m_bus   = DATA[m_owner*W +: W];
                    end
        end
    end

    always @(negedge CLK) begin
        chk("gnt", 32'(GNT), 32'((m_owner >= 0) ? 4'(1 << m_owner) : 4'b0));
        chk("bus_i", 32'(BUS_I), 32'(m_bus));
        chk("bus_t", 32'(BUS_T), 32'((m_owner < 0) || GTS_IN));
        chk("busy", 32'(BUSY), 32'((m_owner >= 0) || (m_dead > 0)));
        chk("gnt_onehot", 32'($countones(GNT) <= 1), 32'(1));
    end

    // Grant-sequence monitor: owner, hold length and preceding high-Z gap per grant.
    logic            mon = 1'b0;
    logic [NREQ-1:0] prev_gnt = '0;
    int              gap = 0;
    int              g_own[$];
    int              g_len[$];
    int              g_gap[$];

    always @(negedge CLK) begin
        if (mon) begin
            if (GNT != 0) begin
                if (GNT != prev_gnt) begin
                    for (int i = 0; i < NREQ; i++)
                        if (GNT[i]) g_own.push_back(i);
                    g_len.push_back(1);
                    g_gap.push_back(gap);
                    gap = 0;
                end else begin
                    g_len[g_len.size()-1] += 1;
                end
            end else begin
                gap++;
            end
            prev_gnt = GNT;
        end
    end

    task automatic wait_gnt(input logic [NREQ-1:0] exp, input string name);
        int n = 0;
        while (GNT == 0 && n < 50) begin
            tick(1);
            n++;
        end
        chk(name, 32'(GNT), 32'(exp));
    endtask

    initial begin
        REQ = 4'b1111;
        tick(3);
        chk("rst_gnt", 32'(GNT), 32'(0));
        chk("rst_bus_t", 32'(BUS_T), 32'(1));
        chk("rst_busy", 32'(BUSY), 32'(0));
        chk("rst_bus_i", 32'(BUS_I), 32'(0));
        RST = 1'b0;
        tick(1);
        chk("rst_release_gnt", 32'(GNT), 32'(4'b0001));
        REQ = '0;
        tick(5);

        REQ = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("single_gnt", 32'(GNT), 32'(4'b0100));
            chk("single_bus_i", 32'(BUS_I), 32'(8'h5A));
            chk("single_bus_t", 32'(BUS_T), 32'(0));
        end
        REQ = '0;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            chk("single_turn_t", 32'(BUS_T), 32'(1));
            chk("single_turn_busy", 32'(BUSY), 32'(1));
        end
        tick(1);
        chk("single_idle_busy", 32'(BUSY), 32'(0));
        chk("single_hold_bus_i", 32'(BUS_I), 32'(8'h5A));

        RST = 1'b1;
        tick(1);
        REQ = 4'b1011;
        mon = 1'b1;
        RST = 1'b0;
        for (int i = 0; i < 200 && g_own.size() < 4; i++) tick(1);
        chk("rr_grant_count", 32'(g_own.size()), 32'(4));
        if (g_own.size() >= 4) begin
            chk("rr_order0", 32'(g_own[0]), 32'(0));
            chk("rr_order1", 32'(g_own[1]), 32'(1));
            chk("rr_order2", 32'(g_own[2]), 32'(3));
            chk("rr_order3", 32'(g_own[3]), 32'(0));
            for (int i = 0; i < 3; i++) chk("rr_len", 32'(g_len[i]), 32'(MB));
            for (int i = 1; i < 4; i++) chk("rr_gap", 32'(g_gap[i]), 32'(TC));
        end
        mon = 1'b0;

        GTS_IN = 1'b1;
        #1;
        chk("gts_bus_t_now", 32'(BUS_T), 32'(1));
        chk("gts_gnt_still", 32'(GNT), 32'(4'b0001));
        tick(1);
        chk("gts_gnt_cleared", 32'(GNT), 32'(0));
        chk("gts_turn_busy", 32'(BUSY), 32'(1));
        tick(10);
        chk("gts_block_gnt", 32'(GNT), 32'(0));
        chk("gts_block_busy", 32'(BUSY), 32'(0));
        GTS_IN = 1'b0;
        tick(1);
        chk("gts_release_gnt", 32'(GNT), 32'(4'b0010));

        REQ = 4'b1001;
        tick(1);
        chk("drop_release", 32'(GNT), 32'(0));
        REQ = 4'b1011;
        wait_gnt(4'b1000, "drop_next_rr");
        REQ = 4'b0010;
        tick(1);
        wait_gnt(4'b0010, "regrant_alone");
        REQ = '0;
        tick(1);
        chk("alone_drop", 32'(GNT), 32'(0));
        REQ = 4'b0010;
        wait_gnt(4'b0010, "regrant_after_drop");

        REQ = 4'b1111;
        tick(2);
        RST = 1'b1;
        #1;
        chk("arst_gnt", 32'(GNT), 32'(0));
        chk("arst_bus_t", 32'(BUS_T), 32'(1));
        chk("arst_busy", 32'(BUSY), 32'(0));
        tick(1);
        RST = 1'b0;
        tick(1);
        chk("arst_ptr_zero", 32'(GNT), 32'(4'b0001));
        REQ = '0;
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
